ysyx_041461_divider: RTL and testbench

//   Iterative radix-2 shift-subtract integer divider for the RV64M DIV/DIVU/REM/REMU
//   and DIVW/DIVUW/REMW/REMUW ops. It is the inverse-direction partner of the Booth

---
 rtl/ysyx_041461_divider.sv | 153 +++++++++++++++
 tb/tb_ysyx_041461_divider.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_041461_divider.sv
// Radix-2 shift-subtract divider for RV64M DIV/DIVU/REM/REMU and their W forms.
// Works on magnitudes and fixes the signs and the word-mode extension when the result is registered.
module ysyx_041461_divider #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            div_valid,
  output logic            div_ready,
  input  logic            div_signed,
  input  logic            div_word,
  input  logic [XLEN-1:0] div_dividend,
  input  logic [XLEN-1:0] div_divisor,
  input  logic            div_flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_quotient,
  output logic [XLEN-1:0] out_remainder
);

  localparam int CNT_W = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic [XLEN-1:0] ext_op(input logic [XLEN-1:0] v, input logic word,
                                             input logic sgn);
    return word ? {{(XLEN-32){sgn & v[31]}}, v[31:0]} : v;
  endfunction

  function automatic logic [XLEN-1:0] word_fix(input logic [XLEN-1:0] v, input logic word);
    return word ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
  endfunction

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]   dsr_q, dsr_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   rmd_q, rmd_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;
  logic              word_q, word_d;

  logic signed [XLEN-1:0] a_ext, b_ext;
  logic [XLEN-1:0]        a_mag, b_mag;
  logic                   sign_a, sign_b;
  logic [XLEN:0]          rem_sh, diff;
  logic [XLEN-1:0]        acc_nx, rem_nx, q_fix, r_fix;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    dsr_d   = dsr_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    word_d  = word_q;

    a_ext  = ext_op(div_dividend, div_word, div_signed);
    b_ext  = ext_op(div_divisor, div_word, div_signed);
    sign_a = div_signed & a_ext[XLEN-1];
    sign_b = div_signed & b_ext[XLEN-1];
    a_mag  = sign_a ? $unsigned(-a_ext) : $unsigned(a_ext);
    b_mag  = sign_b ? $unsigned(-b_ext) : $unsigned(b_ext);

    // acc shifts dividend bits out of the top while quotient bits enter at the bottom
    rem_sh = {rem_q, acc_q[XLEN-1]};
    diff   = rem_sh - {1'b0, dsr_q};
    acc_nx = {acc_q[XLEN-2:0], ~diff[XLEN]};
    rem_nx = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
    q_fix  = word_fix(qneg_q ? (~acc_nx + XLEN'(1)) : acc_nx, word_q);
    r_fix  = word_fix(rneg_q ? (~rem_nx + XLEN'(1)) : rem_nx, word_q);

    if (div_flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (div_valid) begin
            acc_d  = a_mag;
            dsr_d  = b_mag;
            rem_d  = '0;
            cnt_d  = '0;
            qneg_d = sign_a ^ sign_b;
            rneg_d = sign_a;
            word_d = div_word;
            if (b_ext == '0) begin
              quo_d   = '1;
              rmd_d   = word_fix(a_ext, div_word);
              state_d = S_DONE;
            end else begin
              state_d = S_BUSY;
            end
          end
        end
        S_BUSY: begin
          acc_d = acc_nx;
          rem_d = rem_nx;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(XLEN-1)) begin
            quo_d   = q_fix;
            rmd_d   = r_fix;
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      dsr_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      word_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      dsr_q   <= dsr_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      word_q  <= word_d;
    end
  end

  assign div_ready     = (state_q == S_IDLE);
  assign out_valid     = (state_q == S_DONE);
  assign out_quotient  = quo_q;
  assign out_remainder = rmd_q;

endmodule

// File: tb/tb_ysyx_041461_divider.sv
// Randomized and directed bench for ysyx_041461_divider against an arithmetic reference model.
module tb_ysyx_041461_divider;

  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        div_valid = 1'b0;
  logic        div_ready;
  logic        div_signed = 1'b0;
  logic        div_word = 1'b0;
  logic [63:0] div_dividend = '0;
  logic [63:0] div_divisor = '0;
  logic        div_flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_quotient;
  logic [63:0] out_remainder;

  int n_cmp = 0;
  int n_err = 0;

  ysyx_041461_divider #(.XLEN(64)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .div_valid    (div_valid),
    .div_ready    (div_ready),
    .div_signed   (div_signed),
    .div_word     (div_word),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_flush    (div_flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_quotient (out_quotient),
    .out_remainder(out_remainder)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: RISC-V division semantics with plain 64-bit arithmetic
  function automatic void ref_div(input logic [63:0] a, input logic [63:0] b, input logic sgn,
                                  input logic word, output logic [63:0] q,
                                  output logic [63:0] r, output bit bzero);
    logic [63:0] ax, bx;
    longint      sa, sb;
    ax = word ? (sgn ? {{32{a[31]}}, a[31:0]} : {32'b0, a[31:0]}) : a;
    bx = word ? (sgn ? {{32{b[31]}}, b[31:0]} : {32'b0, b[31:0]}) : b;
    bzero = (bx == 64'd0);
    if (bzero) begin
      q = ONES;
      r = ax;
    end else if (sgn) begin
      sa = ax;
      sb = bx;
      if (ax == MIN64 && sb == -1) begin
        q = MIN64;
        r = 64'd0;
      end else begin
        q = sa / sb;
        r = sa % sb;
      end
    end else begin
      q = ax / bx;
      r = ax % bx;
    end
    if (word) begin
      q = {{32{q[31]}}, q[31:0]};
      r = {{32{r[31]}}, r[31:0]};
    end
  endfunction

  task automatic wait_ready();
    int w = 0;
    while (!div_ready && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    chk("accept_ready", 64'(div_ready), 64'd1);
  endtask

  task automatic launch(input logic [63:0] a, input logic [63:0] b, input logic sgn,
                        input logic word);
    wait_ready();
    div_dividend = a;
    div_divisor  = b;
    div_signed   = sgn;
    div_word     = word;
    div_valid    = 1'b1;
    @(posedge clk); #1;
    div_valid = 1'b0;
  endtask

  // Latency counts cycles from the accept edge until out_valid is seen (divide by zero -> 1)
  task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic sgn,
                       input logic word, output logic [63:0] q, output logic [63:0] r,
                       output int lat, output bit busy_ok);
    launch(a, b, sgn, word);
    lat = 1;
    busy_ok = 1'b1;
    while (!out_valid && lat < 200) begin
      if (div_ready) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    q = out_quotient;
    r = out_remainder;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_rand(input logic [63:0] a, input logic [63:0] b, input logic sgn,
                          input logic word, input string tag);
    logic [63:0] q, r, eq, er;
    int          lat;
    bit          busy_ok, bz;
    ref_div(a, b, sgn, word, eq, er, bz);
    do_op(a, b, sgn, word, q, r, lat, busy_ok);
    chk({tag, "_q"}, q, eq);
    chk({tag, "_r"}, r, er);
    chk({tag, "_lat"}, 64'(lat), bz ? 64'd1 : 64'd65);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] q, r, q0, r0, a, b;
    int          lat;
    bit          busy_ok, stable, seen;

    #12;
    chk("rst_ready", 64'(div_ready), 64'd1);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_q", out_quotient, 64'd0);
    chk("rst_r", out_remainder, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(64'd100, 64'd7, 1'b0, 1'b0, q, r, lat, busy_ok);
    chk("divu_q", q, 64'd14);
    chk("divu_r", r, 64'd2);
    chk("divu_lat", 64'(lat), 64'd65);
    chk("divu_busy_ready_low", 64'(busy_ok), 64'd1);
    chk("post_xfer_ready", 64'(div_ready), 64'd1);
    chk("post_xfer_valid", 64'(out_valid), 64'd0);

    do_op(-64'sd7, 64'd2, 1'b1, 1'b0, q, r, lat, busy_ok);
    chk("div_neg_q", q, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("div_neg_r", r, ONES);
    do_op(64'd7, -64'sd2, 1'b1, 1'b0, q, r, lat, busy_ok);
    chk("rem_negb_q", q, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("rem_negb_r", r, 64'd1);

    do_op(64'h1234, 64'd0, 1'b0, 1'b0, q, r, lat, busy_ok);
    chk("dz_q", q, ONES);
    chk("dz_r", r, 64'h1234);
    chk("dz_lat", 64'(lat), 64'd1);
    do_op(MIN64, ONES, 1'b1, 1'b0, q, r, lat, busy_ok);
    chk("ovf_q", q, MIN64);
    chk("ovf_r", r, 64'd0);

    do_op(64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1, q, r, lat, busy_ok);
    chk("divw_ovf_q", q, 64'hFFFF_FFFF_8000_0000);
    chk("divw_ovf_r", r, 64'd0);
    do_op(64'h0000_0000_FFFF_FFFF, 64'd2, 1'b0, 1'b1, q, r, lat, busy_ok);
    chk("divuw_q", q, 64'h0000_0000_7FFF_FFFF);
    chk("divuw_r", r, 64'd1);

    // Backpressure: hold the result for 10 cycles
    launch(64'd1000, 64'd33, 1'b0, 1'b0);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    q0 = out_quotient;
    r0 = out_remainder;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (!out_valid || out_quotient !== q0 || out_remainder !== r0) stable = 1'b0;
    end
    chk("bp_stable", 64'(stable), 64'd1);
    chk("bp_q", q0, 64'd30);
    chk("bp_r", r0, 64'd10);
    out_ready = 1'b1;
    chk("bp_ready_low_at_xfer", 64'(div_ready), 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_ready_after", 64'(div_ready), 64'd1);
    chk("bp_valid_after", 64'(out_valid), 64'd0);

    for (int n = 0; n < 30; n++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: b = 64'd0;
        1: begin a = MIN64; b = ONES; end
        2: b = 64'($urandom_range(1, 300));
        3: b = {32'($urandom), 32'd0};
        4: a = 64'($urandom_range(0, 50));
        default: ;
      endcase
      run_rand(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
    end

    // Flush mid-BUSY, together with a new request
    launch(64'd123456, 64'd789, 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    div_flush = 1'b1;
    div_valid = 1'b1;
    @(posedge clk); #1;
    div_flush = 1'b0;
    div_valid = 1'b0;
    chk("flush_ready", 64'(div_ready), 64'd1);
    chk("flush_valid", 64'(out_valid), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (out_valid || !div_ready) seen = 1'b1;
    end
    chk("flush_no_result", 64'(seen), 64'd0);

    // Flush in DONE beats out_ready
    launch(64'h55, 64'd0, 1'b0, 1'b0);
    chk("dz2_valid", 64'(out_valid), 64'd1);
    div_flush = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    div_flush = 1'b0;
    out_ready = 1'b0;
    chk("flush_done_valid", 64'(out_valid), 64'd0);
    chk("flush_done_ready", 64'(div_ready), 64'd1);

    // Flush in IDLE blocks the accept
    div_dividend = 64'd9;
    div_divisor  = 64'd0;
    div_valid    = 1'b1;
    div_flush    = 1'b1;
    @(posedge clk); #1;
    div_valid = 1'b0;
    div_flush = 1'b0;
    chk("flush_idle_ready", 64'(div_ready), 64'd1);
    chk("flush_idle_valid", 64'(out_valid), 64'd0);

    // Asynchronous reset mid-BUSY
    launch(64'd999, 64'd4, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ready", 64'(div_ready), 64'd1);
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_q", out_quotient, 64'd0);
    chk("arst_r", out_remainder, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_rand(-64'sd1000, 64'd7, 1'b1, 1'b0, "after_rst");
    run_rand(64'h0000_0000_FFFF_FFF0, 64'd0, 1'b0, 1'b1, "after_rst_dzw");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
